adder_pipe_param: RTL

//   Parametrised carry-pipelined adder/subtractor. Each stage adds one SEG-bit slice
//   and registers the carry into the next stage.

---
 rtl/adder_pipe_param.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/adder_pipe_param.sv
// Carry-pipelined adder/subtractor: one SEG-bit slice per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe_param #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_PIPE_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / SEG;

    logic             adv;
    logic [WIDTH-1:0] bp;
    logic             c0;

    // Subtraction folds into the adder as A + ~B + 1 at entry.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign bp       = sub ? ~bin : bin;
    assign c0       = sub | cin;

    function automatic logic [SEG:0] slice_add(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           c);
        return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
    endfunction

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : stg
            localparam int LO = (k + 1) * SEG;

            logic [SEG-1:0] a_sl;
            logic [SEG-1:0] b_sl;
            logic           c_sl;
            logic           v_sl;
            logic [SEG:0]   add;
            logic           vld_p;
            logic           c_p;
            logic [LO-1:0]  s_p;

            assign add = slice_add(a_sl, b_sl, c_sl);

            if (k == 0) begin : g_src
                assign a_sl = ain[SEG-1:0];
                assign b_sl = bp[SEG-1:0];
                assign c_sl = c0;
                assign v_sl = in_valid;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_p <= 1'b0;
                        c_p   <= 1'b0;
                        s_p   <= '0;
                    end else if (adv) begin
                        vld_p <= v_sl;
                        c_p   <= add[SEG];
                        s_p   <= add[SEG-1:0];
                    end
                end
            end else begin : g_src
                // Lowest remaining operand slice of the previous stage meets its carry here.
                assign a_sl = stg[k-1].g_ops.a_p[SEG-1:0];
                assign b_sl = stg[k-1].g_ops.b_p[SEG-1:0];
                assign c_sl = stg[k-1].c_p;
                assign v_sl = stg[k-1].vld_p;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_p <= 1'b0;
                        c_p   <= 1'b0;
                        s_p   <= '0;
                    end else if (adv) begin
                        vld_p <= v_sl;
                        c_p   <= add[SEG];
                        s_p   <= {add[SEG-1:0], stg[k-1].s_p};
                    end
                end
            end

            if (k < STAGES - 1) begin : g_ops
                localparam int RW = WIDTH - LO;
                logic [RW-1:0] a_p;
                logic [RW-1:0] b_p;

                if (k == 0) begin : g_ld
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            a_p <= '0;
                            b_p <= '0;
                        end else if (adv) begin
                            a_p <= ain[WIDTH-1:SEG];
                            b_p <= bp[WIDTH-1:SEG];
                        end
                    end
                end else begin : g_ld
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            a_p <= '0;
                            b_p <= '0;
                        end else if (adv) begin
                            a_p <= stg[k-1].g_ops.a_p[RW+SEG-1:SEG];
                            b_p <= stg[k-1].g_ops.b_p[RW+SEG-1:SEG];
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stg[STAGES-1].vld_p;
    assign sum       = stg[STAGES-1].s_p;
    assign cout      = stg[STAGES-1].c_p;

`ifdef ADDER_PIPE_OVF_EN
    // Top slice holds both operand MSBs, so overflow is judged alongside the final sum bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (adv) begin
            ovf <= (stg[STAGES-1].a_sl[SEG-1] == stg[STAGES-1].b_sl[SEG-1]) &
                   (stg[STAGES-1].add[SEG-1] != stg[STAGES-1].a_sl[SEG-1]);
        end
    end
`endif

endmodule
